// File: rtl/ctrl_pkg.sv
// Shared types and constants for the 5-stage pipeline hazard/flow controller.
package ctrl_pkg;

  localparam int unsigned REG_W = 4;
  localparam logic [REG_W-1:0] REG_ZERO = 4'd0;

  typedef struct packed {
    logic             v;
    logic             we;
    logic [REG_W-1:0] dst;
    logic             h;
  } sh_entry_t;

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    HALTED
  } state_t;

  // True when an in-flight entry will write register r.
  function automatic logic writes_reg(input sh_entry_t e, input logic [REG_W-1:0] r);
    return e.v && e.we && (e.dst == r);
  endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// ID-stage hazard inputs, flush/redirect inputs and stage-control outputs of pipe_ctrl.
interface pipe_ctrl_if #(
  parameter int unsigned CNT_W = 16
);
  import ctrl_pkg::*;

  logic [REG_W-1:0] id_src0;
  logic             id_src0_rd;
  logic [REG_W-1:0] id_src1;
  logic             id_src1_rd;
  logic [REG_W-1:0] id_dst;
  logic             id_we;
  logic             id_hlt;
  logic             ex_jump;
  logic             mem_pcsrc;

  logic             pc_en;
  logic             if_id_en;
  logic             if_id_flush;
  logic             ex_bubble;
  logic             ex_mem_flush;
  logic             mem_wb_en;
  logic             hlt;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output id_src0, id_src0_rd, id_src1, id_src1_rd, id_dst, id_we, id_hlt,
           ex_jump, mem_pcsrc,
    input  pc_en, if_id_en, if_id_flush, ex_bubble, ex_mem_flush, mem_wb_en,
           hlt, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_src0, id_src0_rd, id_src1, id_src1_rd, id_dst, id_we, id_hlt,
           ex_jump, mem_pcsrc,
    output pc_en, if_id_en, if_id_flush, ex_bubble, ex_mem_flush, mem_wb_en,
           hlt, stall_cnt, flush_cnt
  );

endinterface

// File: rtl/pipe_ctrl_shadow.sv
// Three-entry shadow of in-flight destination writes (EX, MEM, WB).
module pipe_ctrl_shadow
  import ctrl_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  sh_entry_t ex_in,
  input  logic      flush_ex,
  input  logic      flush_mem,
  input  logic      freeze,
  output sh_entry_t sh_ex,
  output sh_entry_t sh_mem,
  output sh_entry_t sh_wb
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_ex  <= '0;
      sh_mem <= '0;
      sh_wb  <= '0;
    end else if (!freeze) begin
      sh_wb  <= sh_mem;
      sh_mem <= flush_mem ? '0 : sh_ex;
      sh_ex  <= flush_ex  ? '0 : ex_in;
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard and flow controller: RAW stall, branch/jump squash, halt drain and
// saturating stall/flush counters.
module pipe_ctrl
  import ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic       clk,
  input  logic       rst,
  pipe_ctrl_if.slave bus
);

  state_t           state_q, state_d;
  logic             id_v_q, id_v_d;
  logic             flush_ex, flush_mem, freeze;
  logic             stall_inc, flush_inc;
  logic             hit0, hit1, raw;
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
  sh_entry_t        ex_in, sh_ex, sh_mem, sh_wb;

  assign ex_in = {id_v_q, bus.id_we, bus.id_dst, bus.id_hlt};

  pipe_ctrl_shadow u_shadow (
    .clk       (clk),
    .rst       (rst),
    .ex_in     (ex_in),
    .flush_ex  (flush_ex),
    .flush_mem (flush_mem),
    .freeze    (freeze),
    .sh_ex     (sh_ex),
    .sh_mem    (sh_mem),
    .sh_wb     (sh_wb)
  );

  // No register-file bypass: any in-flight writer of a read source blocks ID.
  always_comb begin
    hit0 = bus.id_src0_rd && (bus.id_src0 != REG_ZERO) &&
           (writes_reg(sh_ex, bus.id_src0) || writes_reg(sh_mem, bus.id_src0) ||
            writes_reg(sh_wb, bus.id_src0));
    hit1 = bus.id_src1_rd && (bus.id_src1 != REG_ZERO) &&
           (writes_reg(sh_ex, bus.id_src1) || writes_reg(sh_mem, bus.id_src1) ||
            writes_reg(sh_wb, bus.id_src1));
    raw  = id_v_q && (hit0 || hit1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      id_v_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      id_v_q  <= id_v_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    id_v_d           = 1'b1;
    flush_ex         = 1'b0;
    flush_mem        = 1'b0;
    freeze           = 1'b0;
    stall_inc        = 1'b0;
    flush_inc        = 1'b0;
    bus.pc_en        = 1'b1;
    bus.if_id_en     = 1'b1;
    bus.if_id_flush  = 1'b0;
    bus.ex_bubble    = 1'b0;
    bus.ex_mem_flush = 1'b0;
    bus.mem_wb_en    = 1'b1;

    if (state_q == HALTED) begin
      bus.pc_en     = 1'b0;
      bus.if_id_en  = 1'b0;
      bus.mem_wb_en = 1'b0;
      freeze        = 1'b1;
      id_v_d        = id_v_q;
    end else begin
      if (bus.mem_pcsrc) begin
        bus.if_id_flush  = 1'b1;
        bus.ex_bubble    = 1'b1;
        bus.ex_mem_flush = 1'b1;
        flush_ex         = 1'b1;
        flush_mem        = 1'b1;
        id_v_d           = 1'b0;
        flush_inc        = 1'b1;
      end else if (bus.ex_jump) begin
        bus.if_id_flush = 1'b1;
        bus.ex_bubble   = 1'b1;
        flush_ex        = 1'b1;
        id_v_d          = 1'b0;
        flush_inc       = 1'b1;
      end else if (raw) begin
        bus.pc_en     = 1'b0;
        bus.if_id_en  = 1'b0;
        bus.ex_bubble = 1'b1;
        flush_ex      = 1'b1;
        id_v_d        = id_v_q;
        stall_inc     = 1'b1;
      end else if (state_q == RUN && id_v_q && bus.id_hlt) begin
        state_d = DRAIN;
      end

      // A branch older than the HLT squashes it and must still redirect the PC.
      if (state_q == DRAIN) begin
        if (bus.mem_pcsrc && sh_ex.v && sh_ex.h) begin
          state_d = RUN;
        end else begin
          bus.pc_en       = 1'b0;
          bus.if_id_flush = 1'b1;
          id_v_d          = 1'b0;
          if (sh_mem.v && sh_mem.h) state_d = HALTED;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall_inc && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (flush_inc && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end

  assign bus.hlt       = (state_q == HALTED);
  assign bus.stall_cnt = stall_cnt_q;
  assign bus.flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: RAW stalls, R0, branch/jump squash, halt drain, reset, saturation.
module tb_pipe_ctrl;

  localparam int unsigned CNT_W = 4;
  // {pc_en, if_id_en, if_id_flush, ex_bubble, ex_mem_flush, mem_wb_en, hlt}
  localparam logic [31:0] C_NORMAL = 32'b1100010;
  localparam logic [31:0] C_STALL  = 32'b0001010;
  localparam logic [31:0] C_BRANCH = 32'b1111110;
  localparam logic [31:0] C_JUMP   = 32'b1111010;
  localparam logic [31:0] C_DRAIN  = 32'b0110010;
  localparam logic [31:0] C_HALT   = 32'b0000001;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  pipe_ctrl_if #(.CNT_W(CNT_W)) bus ();

  pipe_ctrl #(.CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ctl();
    return 32'({bus.pc_en, bus.if_id_en, bus.if_id_flush, bus.ex_bubble,
                bus.ex_mem_flush, bus.mem_wb_en, bus.hlt});
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] s0, input logic r0, input logic [3:0] s1,
                       input logic r1, input logic [3:0] d, input logic we,
                       input logic h, input logic jmp, input logic br);
    bus.id_src0    = s0;
    bus.id_src0_rd = r0;
    bus.id_src1    = s1;
    bus.id_src1_rd = r1;
    bus.id_dst     = d;
    bus.id_we      = we;
    bus.id_hlt     = h;
    bus.ex_jump    = jmp;
    bus.mem_pcsrc  = br;
    #1;
  endtask

  // One pipeline cycle: apply ID/flush inputs, check control outputs, advance.
  task automatic step(input string tag, input logic [3:0] s0, input logic r0,
                      input logic [3:0] s1, input logic r1, input logic [3:0] d,
                      input logic we, input logic h, input logic jmp, input logic br,
                      input logic [31:0] exp);
    drive(s0, r0, s1, r1, d, we, h, jmp, br);
    check(tag, ctl(), exp);
    tick();
  endtask

  // Reset must take effect without a clock edge; leaves ID valid after one idle cycle.
  task automatic do_reset(input string tag);
    rst = 1'b1;
    #1;
    check({tag, "_ctl"}, ctl(), C_NORMAL);
    check({tag, "_stall_cnt"}, 32'(bus.stall_cnt), 32'd0);
    check({tag, "_flush_cnt"}, 32'(bus.flush_cnt), 32'd0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    do_reset("rst_init");

    // Back-to-back dependency on R3: three stall cycles, issue on the fourth.
    step("raw_prod",   0, 0, 0, 0, 3, 1, 0, 0, 0, C_NORMAL);
    step("raw_stall1", 3, 1, 0, 0, 4, 0, 0, 0, 0, C_STALL);
    step("raw_stall2", 3, 1, 0, 0, 4, 0, 0, 0, 0, C_STALL);
    step("raw_stall3", 3, 1, 0, 0, 4, 0, 0, 0, 0, C_STALL);
    step("raw_issue",  3, 1, 0, 0, 4, 0, 0, 0, 0, C_NORMAL);
    check("raw_stall_cnt", 32'(bus.stall_cnt), 32'd3);

    step("r0_prod", 0, 0, 0, 0, 0, 1, 0, 0, 0, C_NORMAL);
    step("r0_read", 0, 1, 0, 1, 0, 0, 0, 0, 0, C_NORMAL);
    check("r0_stall_cnt", 32'(bus.stall_cnt), 32'd3);

    // Unread source is ignored; src1 hazard against producer in MEM then WB.
    step("rd_prod",    0, 0, 0, 0, 5, 1, 0, 0, 0, C_NORMAL);
    step("rd_unread",  5, 0, 0, 0, 0, 0, 0, 0, 0, C_NORMAL);
    step("src1_mem",   0, 0, 5, 1, 0, 0, 0, 0, 0, C_STALL);
    step("src1_wb",    0, 0, 5, 1, 0, 0, 0, 0, 0, C_STALL);
    step("src1_issue", 0, 0, 5, 1, 0, 0, 0, 0, 0, C_NORMAL);
    check("src1_stall_cnt", 32'(bus.stall_cnt), 32'd5);

    // Taken branch squashes EX and ID; their writes must not stall later readers.
    step("br_i8",      0, 0, 0, 0, 8, 1, 0, 0, 0, C_NORMAL);
    step("br_i6",      0, 0, 0, 0, 6, 1, 0, 0, 0, C_NORMAL);
    step("br_flush",   0, 0, 0, 0, 7, 1, 0, 0, 1, C_BRANCH);
    check("br_flush_cnt", 32'(bus.flush_cnt), 32'd1);
    step("br_idle",    0, 0, 0, 0, 0, 0, 0, 0, 0, C_NORMAL);
    step("br_sq_read", 6, 1, 7, 1, 0, 0, 0, 0, 0, C_NORMAL);

    // Jump squashes ID only; the jump itself keeps moving and still writes R9.
    step("j_i9",      0, 0, 0, 0, 9, 1, 0, 0, 0, C_NORMAL);
    step("j_flush",   0, 0, 0, 0, 10, 1, 0, 1, 0, C_JUMP);
    check("j_flush_cnt", 32'(bus.flush_cnt), 32'd2);
    step("j_idle",    0, 0, 0, 0, 0, 0, 0, 0, 0, C_NORMAL);
    step("j_keep_ex", 10, 1, 9, 1, 0, 0, 0, 0, 0, C_STALL);
    step("j_after",   10, 1, 9, 1, 0, 0, 0, 0, 0, C_NORMAL);
    check("j_stall_cnt", 32'(bus.stall_cnt), 32'd6);

    // Branch and jump together: branch pattern, single flush count.
    step("bj_i11",     0, 0, 0, 0, 11, 1, 0, 0, 0, C_NORMAL);
    step("bj_both",    0, 0, 0, 0, 12, 1, 0, 1, 1, C_BRANCH);
    check("bj_flush_cnt", 32'(bus.flush_cnt), 32'd3);
    step("bj_idle",    0, 0, 0, 0, 0, 0, 0, 0, 0, C_NORMAL);
    step("bj_sq_read", 11, 1, 12, 1, 0, 0, 0, 0, 0, C_NORMAL);

    // Hazard coincident with a jump: flush wins, no stall counted.
    step("rf_i13",  0, 0, 0, 0, 13, 1, 0, 0, 0, C_NORMAL);
    step("rf_jump", 13, 1, 0, 0, 0, 0, 0, 1, 0, C_JUMP);
    check("rf_stall_cnt", 32'(bus.stall_cnt), 32'd6);
    check("rf_flush_cnt", 32'(bus.flush_cnt), 32'd4);
    step("rf_idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, C_NORMAL);

    // HLT drain: hlt rises three cycles after issue and stays.
    step("h_issue",  0, 0, 0, 0, 0, 0, 1, 0, 0, C_NORMAL);
    step("h_drain1", 0, 0, 0, 0, 0, 0, 0, 0, 0, C_DRAIN);
    step("h_drain2", 0, 0, 0, 0, 0, 0, 0, 0, 0, C_DRAIN);
    for (int i = 0; i < 10; i++)
      step("h_halted", 0, 0, 0, 0, 0, 0, 0, 0, logic'(i == 4), C_HALT);
    check("h_flush_cnt", 32'(bus.flush_cnt), 32'd4);
    check("h_hlt", 32'(bus.hlt), 32'd1);
    do_reset("rst_halted");

    // Branch older than the HLT squashes it: back to RUN, no halt.
    step("sq_issue",  0, 0, 0, 0, 0, 0, 1, 0, 0, C_NORMAL);
    step("sq_branch", 0, 0, 0, 0, 0, 0, 0, 0, 1, C_BRANCH);
    check("sq_flush_cnt", 32'(bus.flush_cnt), 32'd1);
    for (int i = 0; i < 4; i++)
      step("sq_run", 0, 0, 0, 0, 0, 0, 0, 0, 0, C_NORMAL);

    // Reset in the middle of a RAW stall.
    step("ms_prod",   0, 0, 0, 0, 3, 1, 0, 0, 0, C_NORMAL);
    step("ms_stall1", 3, 1, 0, 0, 0, 0, 0, 0, 0, C_STALL);
    drive(3, 1, 0, 0, 0, 0, 0, 0, 0);
    check("ms_stall2", ctl(), C_STALL);
    check("ms_stall_cnt", 32'(bus.stall_cnt), 32'd1);
    do_reset("rst_stall");

    // Flush counter saturates at all-ones.
    for (int i = 0; i < 15; i++)
      step("sat_flush", 0, 0, 0, 0, 0, 0, 0, 0, 1, C_BRANCH);
    check("sat_at_max", 32'(bus.flush_cnt), 32'd15);
    for (int i = 0; i < 5; i++)
      step("sat_flush", 0, 0, 0, 0, 0, 0, 0, 0, 1, C_BRANCH);
    check("sat_hold", 32'(bus.flush_cnt), 32'd15);
    check("sat_stall_cnt", 32'(bus.stall_cnt), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Hazard and flow controller for the 5-stage IF/ID/EX/MEM/WB CPU pipeline. It replaces the tied-high stage enables with real stall, bubble and flush control. It keeps a 3-entry shadow of the in-flight destination writes (EX, MEM, WB) to detect read-after-write hazards in ID. It squashes wrong-path instructions on a taken branch (resolved in MEM) or a jump (resolved in EX), and it sequences the halt drain.

## Interface
Parameters:
- CNT_W, 16, width of the saturating performance counters

Ports:
- clk  in  1  pipeline clock
- rst  in  1  reset, asynchronous, active-high
- id_src0  in  4  ID source-0 register address
- id_src0_rd  in  1  ID instruction reads src0
- id_src1  in  4  ID source-1 register address
- id_src1_rd  in  1  ID instruction reads src1
- id_dst  in  4  ID destination address
- id_we  in  1  ID instruction writes the register file
- id_hlt  in  1  ID instruction is HLT
- ex_jump  in  1  jump resolved in EX this cycle
- mem_pcsrc  in  1  taken branch resolved in MEM this cycle
- pc_en  out  1  PC update enable
- if_id_en  out  1  IF/ID load enable
- if_id_flush  out  1  IF/ID loads a NOP
- ex_bubble  out  1  ID/EX loads a NOP
- ex_mem_flush  out  1  EX/MEM loads a NOP
- mem_wb_en  out  1  MEM/WB enable
- hlt  out  1  processor halted
- stall_cnt  out  CNT_W  cycles stalled on RAW
- flush_cnt  out  CNT_W  flush events

## Operation
- The shadow entries sh_ex, sh_mem and sh_wb each hold {v, we, dst, h}. Internal id_v marks ID as holding a valid instruction.
- RAW hazard, `raw`: id_v is set and, for any read source s ≠ R0, s equals some shadow entry with v=1 and we=1. The register file does not bypass, so a consumer waits until its producer has left WB.
- Priority per cycle, highest first: HALTED, then mem_pcsrc, then ex_jump, then raw, then normal.
- mem_pcsrc:
  - Assert if_id_flush, ex_bubble and ex_mem_flush; pc_en=1.
  - At the edge: sh_wb←sh_mem, sh_mem←0, sh_ex←0, id_v←0.
  - Increment flush_cnt.
- ex_jump:
  - Assert if_id_flush and ex_bubble; pc_en=1.
  - At the edge: shift with sh_ex←0, id_v←0.
  - Increment flush_cnt.
- raw:
  - pc_en=0, if_id_en=0, ex_bubble=1.
  - At the edge: shift with sh_ex←0; id_v is held.
  - Increment stall_cnt.
- Normal:
  - All enables high.
  - At the edge: sh_ex←{id_v, id_we, id_dst, id_hlt}; id_v←1.
- mem_wb_en is always 1 except in HALTED.
- FSM states RUN, DRAIN, HALTED:
  - RUN→DRAIN when an id_hlt instruction issues normally into EX.
  - In DRAIN: pc_en=0 and if_id_flush=1; id_v←0.
  - DRAIN→RUN if mem_pcsrc fires while sh_ex.h=1, because the halt was squashed.
  - DRAIN→HALTED at the edge where sh_mem.h moves into WB.
  - HALTED: every enable is 0, all flush/bubble outputs are 0, hlt=1. HALTED holds until rst.
- Counters saturate at all-ones and never wrap.

## Timing
- Reset (async) sets:
  - state=RUN, all shadow entries 0, id_v=0, counters 0, hlt=0
  - outputs pc_en=1, if_id_en=1, mem_wb_en=1, all flush/bubble outputs 0
- All control outputs are combinational from the registered state, shadow, id_v and current-cycle inputs. They are valid within the same cycle to gate the stage flops.
- Back-to-back dependent instructions stall exactly 3 cycles, with the producer in EX, then MEM, then WB. The consumer issues in the 4th cycle.
- A taken branch costs 3 bubbles. A jump costs 2.
- hlt rises 3 cycles after HLT leaves ID, with no intervening squash.
- Simultaneous mem_pcsrc and ex_jump: the mem_pcsrc actions apply and the jump is discarded. flush_cnt increments once.
- Simultaneous raw and any flush: the flush wins and stall_cnt does not increment.
- Reset asserted mid-stall or mid-drain returns immediately to the reset state.

## Structure
- Shared package `ctrl_pkg`:
  - shadow-entry struct {v, we, dst[3:0], h}
  - state enum {RUN, DRAIN, HALTED}
  - REG_ZERO = 4'd0
- Sub-module `pipe_ctrl_shadow` is the 3-entry shift register, with inputs flush_ex, flush_mem and freeze. `pipe_ctrl` holds the FSM, the hazard compare, the output decode and the counters.

## Test plan
- Write R3 then read R3 back-to-back: raw=1 for 3 cycles, pc_en=0 for 3 cycles, consumer issues on cycle 4, stall_cnt=3.
- Read of R0 after a write to R0: no stall, stall_cnt=0.
- mem_pcsrc pulse with valid instructions in ID and EX: if_id_flush, ex_bubble and ex_mem_flush high for 1 cycle; sh_ex and sh_mem cleared; flush_cnt=1.
- ex_jump and mem_pcsrc in the same cycle: exactly the branch flush pattern; flush_cnt increments by 1.
- HLT issued, then no branch: hlt=1 exactly 3 cycles after issue; enables stay 0 for 10 further cycles. Repeat with mem_pcsrc while HLT is in EX: the FSM returns to RUN and hlt stays 0.
- rst asserted during a raw stall and again in HALTED: outputs return to their reset values without waiting for a clk edge.
